imem_loader: RTL and testbench

Boot-time instruction-memory loader that sits directly upstream of the single-cycle core's instruction memory. It accepts a byte stream (length header plus little-endian instruction words), assembles 32-bit words and writes them into the imem. It holds the core in reset until the image is complete, replacing simulation-only `$readmemh` preloading with a path that synthesises.

---
 rtl/imem_loader.sv | 99 +++++++++
 tb/tb_imem_loader.sv | 138 +++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot loader streaming a length-prefixed byte image into imem; define IMEM_LOADER_CKSUM_EN for a trailing checksum byte.
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   words_loaded
);
`ifdef IMEM_LOADER_CKSUM_EN
  typedef enum logic [2:0] {HDR0, HDR1, DATA, CKSUM, DONE, ERR} state_t;
  logic [7:0] acc;
`else
  typedef enum logic [2:0] {HDR0, HDR1, DATA, DONE, ERR} state_t;
`endif
  localparam logic [16:0] CAP = 17'd1 << ADDR_WIDTH;
  state_t state;
  logic [15:0] n;
  logic [1:0] idx;
  logic [23:0] lanes;
  logic take, last;
  assign in_ready = state != DONE && state != ERR;
  assign take = in_valid & in_ready;
  assign last = 16'(words_loaded) + 16'd1 == n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HDR0;
      n <= '0;
      idx <= '0;
      lanes <= '0;
      imem_we <= 1'b0;
      imem_addr <= '0;
      imem_wdata <= '0;
      core_hold <= 1'b1;
      load_done <= 1'b0;
      load_err <= 1'b0;
      words_loaded <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      acc <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      // release lags DONE by one cycle so the last write commits before the first fetch
      core_hold <= state != DONE;
      if (take) begin
        case (state)
          HDR0: begin
            n[7:0] <= in_data;
            state <= HDR1;
          end
          HDR1: begin
            n[15:8] <= in_data;
            if ({in_data, n[7:0]} == 16'd0 || {1'b0, in_data, n[7:0]} > CAP) begin
              state <= ERR;
              load_err <= 1'b1;
            end else state <= DATA;
          end
          DATA: begin
            idx <= idx + 2'd1;
            lanes <= {in_data, lanes[23:8]};
`ifdef IMEM_LOADER_CKSUM_EN
            acc <= acc + in_data;
`endif
            if (idx == 2'd3) begin
              imem_we <= 1'b1;
              imem_addr <= words_loaded[ADDR_WIDTH-1:0];
              imem_wdata <= {in_data, lanes};
              words_loaded <= words_loaded + 1'b1;
              if (last) begin
`ifdef IMEM_LOADER_CKSUM_EN
                state <= CKSUM;
`else
                state <= DONE;
                load_done <= 1'b1;
`endif
              end
            end
          end
`ifdef IMEM_LOADER_CKSUM_EN
          CKSUM: begin
            state <= in_data == acc ? DONE : ERR;
            load_done <= in_data == acc;
            load_err <= in_data != acc;
          end
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized image streams checked against a word-list reference model.
module tb_imem_loader;
  localparam int AW = 10;
  logic clk = 0, rst = 1, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, imem_we, core_hold, load_done, load_err;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [AW:0] words_loaded;
  int vectors = 0, miscompares = 0;
  logic [AW+31:0] obs[$];
  logic [31:0] wq[$];
  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_hold(core_hold),
    .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (imem_we) obs.push_back({imem_addr, imem_wdata});
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    in_valid = 0;
    @(negedge clk);
    obs.delete();
    check("rst_rdy", in_ready, 1);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_hold", core_hold, 1);
    check("rst_done", load_done, 0);
    check("rst_err", load_err, 0);
    check("rst_wl", words_loaded, 0);
    rst = 0;
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    int g = gap < 0 ? int'($urandom_range(0, 2)) : gap;
    repeat (g) @(negedge clk);
    in_valid = 1;
    in_data = b;
    @(negedge clk);
    in_valid = 0;
    in_data = 8'($urandom);
  endtask
  task automatic run_stream(input int gap, input bit bad_ck);
    int n = wq.size();
    logic [7:0] sum = 0;
    logic [7:0] b;
    send(n[7:0], gap);
    send(n[15:8], gap);
    check("hdr_err", load_err, 0);
    check("hdr_rdy", in_ready, 1);
    foreach (wq[i])
      for (int k = 0; k < 4; k++) begin
        b = wq[i][8*k +: 8];
        sum += b;
        send(b, gap);
      end
`ifdef IMEM_LOADER_CKSUM_EN
    send(bad_ck ? sum + 8'd1 : sum, gap);
`else
    check("last_we", imem_we, 1);
    check("last_addr", imem_addr, 64'(n - 1));
    check("last_wdata", imem_wdata, wq[n-1]);
`endif
    check("wl", words_loaded, n);
    check("hold_t1", core_hold, 1);
    check("done", load_done, !bad_ck);
    check("err", load_err, bad_ck);
    check("rdy_end", in_ready, 0);
    @(negedge clk);
    check("hold_t2", core_hold, bad_ck);
    check("we_once", imem_we, 0);
    check("nwr", obs.size(), n);
    for (int i = 0; i < n && i < obs.size(); i++) check("wr", obs[i], {AW'(i), wq[i]});
  endtask
  task automatic hdr_bad(input logic [7:0] b0, input logic [7:0] b1);
    do_reset();
    send(b0, 0);
    send(b1, 0);
    check("bad_err", load_err, 1);
    check("bad_rdy", in_ready, 0);
    check("bad_hold", core_hold, 1);
    check("bad_done", load_done, 0);
    send(8'($urandom), 0);
    send(8'($urandom), 0);
    @(negedge clk);
    check("bad_nwr", obs.size(), 0);
    check("bad_hold2", core_hold, 1);
    check("bad_wl", words_loaded, 0);
  endtask
  initial begin
    do_reset();
    wq.delete();
    wq.push_back(32'h0000_0293);
    wq.push_back(32'h0000_0313);
    run_stream(0, 0);
    repeat (6) begin
      do_reset();
      wq.delete();
      repeat ($urandom_range(1, 8)) wq.push_back($urandom);
      run_stream(-1, 0);
    end
    do_reset();
    wq.delete();
    wq.push_back($urandom);
    run_stream(1, 0);
    hdr_bad(8'h00, 8'h00);
    hdr_bad(8'h01, 8'h04);
    do_reset();
    wq.delete();
    repeat (1 << AW) wq.push_back($urandom);
    run_stream(0, 0);
    do_reset();
    send(8'd3, 0);
    send(8'd0, 0);
    repeat (6) send(8'($urandom), -1);
    do_reset();
    wq.delete();
    wq.push_back($urandom);
    run_stream(0, 0);
`ifdef IMEM_LOADER_CKSUM_EN
    do_reset();
    wq.delete();
    repeat (3) wq.push_back($urandom);
    run_stream(-1, 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
